// File: rtl/ctr.sv
// Control unit for the accumulator core: fetches 8-bit instructions over a
// req/ack memory port and sequences NOR/ADD/STA/JCC on the `dat` datapath.

`ifndef OP_WIDTH
`define OP_WIDTH 2
`endif
`ifndef OP_NOR
`define OP_NOR 2'b00
`endif
`ifndef OP_ADD
`define OP_ADD 2'b01
`endif
`ifndef OP_JCC
`define OP_JCC 2'b11
`endif
`ifndef CTR_CARRYMUX_WIDTH
`define CTR_CARRYMUX_WIDTH 2
`endif
`ifndef CARRY_OP_KEEP
`define CARRY_OP_KEEP 2'b00
`endif
`ifndef CARRY_OP_GEN
`define CARRY_OP_GEN 2'b01
`endif
`ifndef CARRY_OP_CLR
`define CARRY_OP_CLR 2'b10
`endif

// Memory handshake: mem_req_o is raised with mem_addr_o/mem_we_o and they are
// held unchanged until a cycle where mem_ack_i=1; that cycle completes exactly
// one access (ack may coincide with the first req cycle). Ack with req=0 is ignored.
module ctr #(
  parameter int                  DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-3:0] RESET_VECTOR = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_WIDTH-1:0]          mem_data_i,
  input  logic                           mem_ack_i,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [DATA_WIDTH-3:0]          mem_addr_o,
  input  logic                           carry_i,
  output logic [`OP_WIDTH-1:0]           ctr_aluop_o,
  output logic [`CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_o,
  output logic                           ctr_a_reg_en_o,
  output logic [DATA_WIDTH-3:0]          pc_o,
  output logic                           halt_o
);

  localparam int ADDR_WIDTH = DATA_WIDTH - 2;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC_RD = 3'd2,
    S_STORE   = 3'd3,
    S_JUMP    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;

  logic [1:0]            ir_op;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [1:0]            fetch_op;
  logic [ADDR_WIDTH-1:0] pc_prev;

  assign ir_op    = ir[DATA_WIDTH-1:DATA_WIDTH-2];
  assign ir_addr  = ir[ADDR_WIDTH-1:0];
  assign fetch_op = mem_data_i[DATA_WIDTH-1:DATA_WIDTH-2];
  // PC has already advanced past the JCC, so PC-1 is the JCC's own address.
  assign pc_prev  = pc - 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_START;
      pc    <= RESET_VECTOR;
      ir    <= '0;
    end else begin
      case (state)
        S_START: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack_i) begin
            ir <= mem_data_i;
            pc <= pc + 1'b1;
            case (fetch_op)
              2'b00, 2'b01: state <= S_EXEC_RD;
              2'b10:        state <= S_STORE;
              default:      state <= S_JUMP;
            endcase
          end
        end
        S_EXEC_RD, S_STORE: begin
          if (mem_ack_i) state <= S_FETCH;
        end
        S_JUMP: begin
          if (!carry_i) begin
            pc    <= ir_addr;
            state <= (ir_addr == pc_prev) ? S_HALT : S_FETCH;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_START;
      endcase
    end
  end

  // Outputs decode straight from the state so reset takes effect immediately.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    ctr_aluop_o    = `OP_NOR;
    ctr_carrymux_o = `CARRY_OP_KEEP;
    ctr_a_reg_en_o = 1'b0;
    halt_o         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc;
      end
      S_EXEC_RD: begin
        mem_req_o      = 1'b1;
        mem_addr_o     = ir_addr;
        ctr_aluop_o    = (ir_op == 2'b01) ? `OP_ADD : `OP_NOR;
        ctr_a_reg_en_o = mem_ack_i;
        if (ir_op == 2'b01 && mem_ack_i) ctr_carrymux_o = `CARRY_OP_GEN;
      end
      S_STORE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = ir_addr;
      end
      S_JUMP: begin
        ctr_aluop_o    = `OP_JCC;
        ctr_carrymux_o = `CARRY_OP_CLR;
      end
      S_HALT:  halt_o = 1'b1;
      default: ;
    endcase
  end

  assign pc_o = pc;

endmodule

// File: tb/tb_ctr.sv
// Bench for ctr: instruction-level reference interpreter produces the expected
// memory-access sequence; a per-cycle compare process checks the DUT against it.
module tb_ctr;
  localparam logic [1:0] OP_NOR = 2'b00, OP_ADD = 2'b01;
  localparam logic [1:0] CM_KEEP = 2'b00, CM_GEN = 2'b01, CM_CLR = 2'b10;
  localparam logic [1:0] K_FETCH = 2'd0, K_NOR = 2'd1, K_ADD = 2'd2, K_STORE = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_data = '0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we;
  logic [5:0] mem_addr, pc;
  logic       carry = 1'b0;
  logic [1:0] aluop, cmux;
  logic       aen, halt;

  ctr #(.DATA_WIDTH(8), .RESET_VECTOR(6'd0)) dut (
    .clk_i(clk), .rst_i(rst), .mem_data_i(mem_data), .mem_ack_i(mem_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .carry_i(carry), .ctr_aluop_o(aluop), .ctr_carrymux_o(cmux),
    .ctr_a_reg_en_o(aen), .pc_o(pc), .halt_o(halt)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory responder
  logic [7:0] mem[64];
  int  wait_n = 0, ack_limit = 1000000, acks = 0, wcnt = 0;
  bit  stray = 1'b0;
  initial forever begin
    @(posedge clk or posedge rst);
    #1;
    if (rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      if (wcnt >= wait_n && acks < ack_limit) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        wcnt     = 0;
        acks++;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = stray;
      wcnt    = 0;
    end
  end

  // reference interpreter: builds the expected access list {kind, addr}
  logic [7:0] exp_q[$];
  int clr_exp = 0;
  bit mdl_halt = 1'b0;
  task automatic build_model(input bit c, input int k);
    logic [5:0] mpc, tgt, self_addr;
    logic [7:0] ir;
    int n;
    bit last_jcc;
    exp_q.delete();
    clr_exp = 0; mdl_halt = 1'b0; mpc = 6'd0; n = 0; last_jcc = 1'b0;
    while (!(n >= k && !last_jcc)) begin
      ir = mem[mpc];
      exp_q.push_back({K_FETCH, mpc});
      n++;
      self_addr = mpc;
      mpc = mpc + 6'd1;
      tgt = ir[5:0];
      last_jcc = 1'b0;
      case (ir[7:6])
        2'b00: begin exp_q.push_back({K_NOR, tgt}); n++; end
        2'b01: begin exp_q.push_back({K_ADD, tgt}); n++; end
        2'b10: begin exp_q.push_back({K_STORE, tgt}); n++; end
        default: begin
          clr_exp++;
          last_jcc = 1'b1;
          if (!c) begin
            if (tgt == self_addr) begin
              mdl_halt = 1'b1;
              break;
            end
            mpc = tgt;
          end
        end
      endcase
    end
  endtask

  // per-cycle compare process + cycle log for literal pins
  bit check_en = 1'b0;
  int clr_seen = 0;
  logic [7:0] log_req[64], log_aen[64], log_we[64], log_halt[64];
  logic [7:0] log_addr[64], log_pc[64], log_cmux[64];
  initial begin
    logic [7:0] e;
    bit prev_wait;
    logic [5:0] prev_addr;
    logic prev_we;
    logic [1:0] prev_aluop;
    prev_wait = 1'b0; prev_addr = '0; prev_we = 1'b0; prev_aluop = '0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        if (cyc < 64) begin
          log_req[cyc] = {7'd0, mem_req}; log_aen[cyc] = {7'd0, aen};
          log_we[cyc] = {7'd0, mem_we}; log_halt[cyc] = {7'd0, halt};
          log_addr[cyc] = {2'd0, mem_addr}; log_pc[cyc] = {2'd0, pc};
          log_cmux[cyc] = {6'd0, cmux};
        end
        if (mem_req && prev_wait) begin
          check("stable_addr", mem_addr, prev_addr);
          check("stable_we", mem_we, prev_we);
          check("stable_aluop", aluop, prev_aluop);
        end
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_access", mem_req, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("acc_addr", mem_addr, e[5:0]);
            check("acc_we", mem_we, e[7:6] == K_STORE);
            check("acc_aen", aen, e[7:6] == K_NOR || e[7:6] == K_ADD);
            check("acc_cmux", cmux, (e[7:6] == K_ADD) ? CM_GEN : CM_KEEP);
            if (e[7:6] == K_NOR) check("acc_aluop", aluop, OP_NOR);
            if (e[7:6] == K_ADD) check("acc_aluop", aluop, OP_ADD);
          end
        end else if (mem_req) begin
          check("wait_aen", aen, 1'b0);
          check("wait_cmux", cmux, CM_KEEP);
        end else begin
          check("idle_aen", aen, 1'b0);
          check("idle_cmux", cmux == CM_KEEP || cmux == CM_CLR, 1'b1);
          if (cmux == CM_CLR) clr_seen++;
        end
        prev_wait  = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_aluop = aluop;
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  task automatic run_test(input bit c, input int wn, input bit st, input int k);
    int budget;
    check_en = 1'b0;
    rst = 1'b1;
    carry = c; wait_n = wn; stray = st; ack_limit = 1000000; acks = 0;
    build_model(c, k);
    clr_seen = 0;
    foreach (log_req[i]) begin
      log_req[i] = 8'hEE; log_aen[i] = 8'hEE; log_we[i] = 8'hEE; log_halt[i] = 8'hEE;
      log_addr[i] = 8'hEE; log_pc[i] = 8'hEE; log_cmux[i] = 8'hEE;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0; cyc = 0; check_en = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 600) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check("model_drained", exp_q.size(), 0);
    if (mdl_halt) begin
      repeat (2) @(negedge clk);
      #1;
      repeat (5) begin
        check("halt_hold", halt, 1'b1);
        check("halt_no_req", mem_req, 1'b0);
        @(negedge clk);
        #1;
      end
    end
    check("clr_count", clr_seen, clr_exp);
    check_en = 1'b0;
  endtask

  function automatic int aen_count();
    int n = 0;
    foreach (log_aen[i]) if (log_aen[i] == 8'd1) n++;
    return n;
  endfunction

  initial begin
    // 1: zero-wait ADD chain, halting JCC at 2
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h48; mem[2] = 8'hC2; mem[8] = 8'h01;
    run_test(1'b0, 0, 1'b0, 100);
    check("t1_aen_c2", log_aen[2], 8'd1);
    check("t1_aen_c3", log_aen[3], 8'd0);
    check("t1_aen_c4", log_aen[4], 8'd1);
    check("t1_gen_c2", log_cmux[2], {6'd0, CM_GEN});
    check("t1_gen_c4", log_cmux[4], {6'd0, CM_GEN});
    check("t1_pc_c4", log_pc[4], 8'd2);
    check("t1_clr_c6", log_cmux[6], {6'd0, CM_CLR});
    check("t1_halt_c6", log_halt[6], 8'd0);
    check("t1_halt_c7", log_halt[7], 8'd1);

    // 2: same program, 3 wait states, stray acks while idle
    run_test(1'b0, 3, 1'b1, 100);
    check("t2_aen_count", aen_count(), 2);
    check("t2_final_pc", pc, 6'd2);

    // 3: STA
    clear_mem();
    mem[0] = 8'h8A; mem[1] = 8'hC1;
    run_test(1'b0, 0, 1'b0, 100);
    check("t3_we_c2", log_we[2], 8'd1);
    check("t3_addr_c2", log_addr[2], 8'h0A);
    check("t3_cmux_c2", log_cmux[2], {6'd0, CM_KEEP});
    check("t3_aen_count", aen_count(), 0);

    // 4: JCC with carry set falls through
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h05; mem[2] = 8'h05; mem[3] = 8'hD0;
    mem[4] = 8'h06; mem[5] = 8'h06; mem[16] = 8'hD0;
    run_test(1'b1, 0, 1'b0, 9);
    check("t4_clr_c8", log_cmux[8], {6'd0, CM_CLR});
    check("t4_req_c8", log_req[8], 8'd0);
    check("t4_fetch_c9", log_addr[9], 8'h04);

    // 5: JCC with carry clear jumps to 0x10, which halts
    run_test(1'b0, 0, 1'b0, 100);
    check("t5_fetch_c9", log_addr[9], 8'h10);
    check("t5_final_pc", pc, 6'h10);

    // 6: halt at jump-to-self
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 8'h20;
    mem[5] = 8'hC5;
    run_test(1'b0, 0, 1'b0, 100);
    check("t6_clr_c12", log_cmux[12], {6'd0, CM_CLR});
    check("t6_halt_c12", log_halt[12], 8'd0);
    check("t6_halt_c13", log_halt[13], 8'd1);
    check("t6_final_pc", pc, 6'd5);

    // 7: async reset during EXEC_RD with ack withheld
    clear_mem();
    mem[0] = 8'h48;
    check_en = 1'b0; rst = 1'b1; carry = 1'b0; wait_n = 0; stray = 1'b0;
    ack_limit = 1; acks = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t7_exec_req", mem_req, 1'b1);
    check("t7_exec_addr", mem_addr, 6'h08);
    check("t7_exec_aluop", aluop, OP_ADD);
    check("t7_exec_aen", aen, 1'b0);
    check("t7_exec_pc", pc, 6'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_req", mem_req, 1'b0);
    check("t7_rst_we", mem_we, 1'b0);
    check("t7_rst_addr", mem_addr, 6'd0);
    check("t7_rst_aen", aen, 1'b0);
    check("t7_rst_cmux", cmux, CM_KEEP);
    check("t7_rst_aluop", aluop, OP_NOR);
    check("t7_rst_halt", halt, 1'b0);
    check("t7_rst_pc", pc, 6'd0);
    ack_limit = 1000000;
    @(negedge clk);
    #1 rst = 1'b0;
    check("t7_start_req", mem_req, 1'b0);
    @(negedge clk);
    #1;
    check("t7_fetch_req", mem_req, 1'b1);
    check("t7_fetch_addr", mem_addr, 6'd0);
    check("t7_fetch_we", mem_we, 1'b0);

    // 8: PC wrap after fetch at 0x3F
    clear_mem();
    mem[0] = 8'hFF; mem[63] = 8'h01;
    run_test(1'b0, 0, 1'b0, 6);
    check("t8_fetch_c3", log_addr[3], 8'h3F);
    check("t8_pc_c3", log_pc[3], 8'h3F);
    check("t8_pc_wrap_c4", log_pc[4], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ctr.md
Name: ctr

Overview:
- Control unit for the accumulator core; drives the `dat` datapath control inputs (aluop, carrymux, A-register enable) and consumes its carry.
- Fetches 8-bit instructions from a shared program/data memory over a req/ack handshake.
- Executes the four-instruction set NOR/ADD/STA/JCC and sequences operand reads and accumulator stores.
- Sits between memory and `dat`. Memory read data feeds `dat.data_i` directly; `dat.data_o` feeds memory write data.

Parameters:
- DATA_WIDTH, 8, instruction/data word width; opcode in bits [DATA_WIDTH-1:DATA_WIDTH-2], address in the remaining bits.
- RESET_VECTOR, 0, PC value loaded on reset; width DATA_WIDTH-2.
- ADDR_WIDTH (localparam), DATA_WIDTH-2, memory address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_data_i  in  DATA_WIDTH  memory read data; valid in the mem_ack_i cycle.
- mem_ack_i  in  1  access complete this cycle.
- mem_req_o  out  1  access request; held with stable addr/we until ack.
- mem_we_o  out  1  1 = write (STA), 0 = read.
- mem_addr_o  out  ADDR_WIDTH  access address.
- carry_i  in  1  carry from dat.
- ctr_aluop_o  out  `OP_WIDTH  ALU operation to dat.
- ctr_carrymux_o  out  `CTR_CARRYMUX_WIDTH  carry source: `CARRY_OP_GEN / `CARRY_OP_CLR / `CARRY_OP_KEEP.
- ctr_a_reg_en_o  out  1  accumulator load enable.
- pc_o  out  ADDR_WIDTH  current PC (debug).
- halt_o  out  1  core halted.

Behaviour:
- Opcode decode: 00 NOR (`OP_NOR), 01 ADD (`OP_ADD), 10 STA, 11 JCC (`OP_JCC). IR holds the latched instruction.
- States: START, FETCH, EXEC_RD, STORE, JUMP, HALT.
- Reset (async, any state, including mid-access):
  - State = START, PC = RESET_VECTOR, IR = 0.
  - Outputs: mem_req_o=0, mem_we_o=0, mem_addr_o=0, ctr_a_reg_en_o=0, ctr_carrymux_o=`CARRY_OP_KEEP, ctr_aluop_o=`OP_NOR, halt_o=0.
  - A pending access is abandoned without waiting for ack.
- START: one cycle with no request, then FETCH.
- FETCH:
  - mem_req_o=1, we=0, addr=PC.
  - On ack: IR <= mem_data_i, PC <= PC+1 (wraps 2^ADDR_WIDTH-1 -> 0).
  - Next state: NOR/ADD -> EXEC_RD, STA -> STORE, JCC -> JUMP.
- EXEC_RD:
  - mem_req_o=1, we=0, addr=IR.addr, ctr_aluop_o=IR op.
  - ctr_a_reg_en_o = mem_ack_i (combinational; A loads at the ack edge).
  - ctr_carrymux_o = `CARRY_OP_GEN when the op is ADD and mem_ack_i=1, else KEEP. NOR never changes carry.
  - On ack -> FETCH.
- STORE:
  - mem_req_o=1, we=1, addr=IR.addr. Accumulator unchanged; carrymux KEEP.
  - On ack -> FETCH.
- JUMP: exactly one cycle, no memory access, carrymux=`CARRY_OP_CLR.
  - If carry_i=0: PC <= IR.addr, else PC unchanged.
  - If carry_i=0 and IR.addr == PC-1 (jump to self), next state HALT, else FETCH.
- HALT: halt_o=1, no requests, carrymux KEEP. Left only by reset.
- Outside the cases above, ctr_a_reg_en_o=0 and ctr_carrymux_o=`CARRY_OP_KEEP.
- Handshake:
  - Ack may arrive in the same cycle as req (zero wait) or any number of cycles later.
  - Addr/we/aluop stay stable while waiting.
  - Ack while req=0 is ignored.
  - Back-to-back accesses may keep req high; one ack completes exactly one access.
- Instruction latency with zero-wait memory: NOR/ADD/STA take 2 cycles, JCC takes 2 cycles.

Test Plan:
- Zero-wait ADD chain: mem[0]=0x48 (ADD 8), mem[1]=0x48, mem[8]=0x01 -> a_reg_en pulses in cycles 2 and 4 after START, carrymux GEN on those cycles, PC=2 after the 4th fetch cycle.
- Wait states: ack delayed 3 cycles on each access -> req/addr/we stable throughout, a_reg_en asserted only in ack cycles, same final PC as zero-wait.
- STA: mem[0]=0x8A -> cycle-2 access has we=1, addr=0x0A; a_reg_en=0 and carrymux KEEP throughout.
- JCC with carry_i=1 at mem[3]=0xD0 -> carrymux CLR for 1 cycle, next fetch addr=4. With carry_i=0 -> next fetch addr=0x10.
- Halt: mem[5]=0xC5, carry_i=0 -> halt_o=1 from the cycle after JUMP, mem_req_o stays 0 indefinitely.
- Reset and wrap:
  - Assert rst_i mid-EXEC_RD with ack withheld -> outputs take reset values immediately (asynchronously); after release, a START cycle, then fetch at RESET_VECTOR.
  - Fetch at 0x3F -> PC wraps to 0.
